// File: rtl/mac_tx_interface.sv
// Streams committed frames from the 64-bit circular buffer into the MAC Tx client.
// Two-entry prefetch hides the one-cycle RAM read latency during streaming.
module mac_tx_interface #(
  parameter int AW        = 10,
  parameter int MAX_BYTES = 9600
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] commited_wr_address,
  output logic [AW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic [AW-1:0] commited_rd_address,
  output logic [63:0]   tx_data,
  output logic [7:0]    tx_data_valid,
  output logic          tx_start,
  input  logic          tx_ack,
  output logic          tx_underrun,
  output logic [31:0]   sent_frames_counter,
  output logic [31:0]   dropped_frames_counter
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_WAIT_ACK,
    S_STREAM, S_DROP, S_COMMIT
  } state_t;

  state_t        state;
  logic [AW-1:0] fp;
  logic [7:0]    lane_last;
  logic [15:0]   fetch_left;
  logic [15:0]   send_left;
  logic [63:0]   q0, q1, q0_n, q1_n;
  logic [1:0]    cnt, cnt_n;
  logic          pend;

  logic [31:0]   hdr_n;
  logic [32:0]   hdr_words;
  logic          hdr_ok;
  logic [7:0]    hdr_lanes;
  logic [63:0]   head;
  logic [7:0]    lanes_now;
  logic          pop, fetch_en, issue;

  assign tx_underrun = 1'b0;

  assign hdr_n     = rd_data[63:32];
  assign hdr_words = ({1'b0, hdr_n} + 33'd7) >> 3;
  assign hdr_ok    = (hdr_n != 32'd0) &&
                     (hdr_n <= 32'(MAX_BYTES));
  assign hdr_lanes = (hdr_n[2:0] == 3'd0) ? 8'hFF :
                     (8'd1 << hdr_n[2:0]) - 8'd1;

  assign head      = (cnt != 2'd0) ? q0 : rd_data;
  assign lanes_now = (send_left == 16'd1) ? lane_last : 8'hFF;

  assign pop = (state == S_LOAD) || (state == S_STREAM) ||
               ((state == S_WAIT_ACK) && tx_ack &&
                (send_left != 16'd0));
  assign fetch_en = (state == S_LOAD) || (state == S_WAIT_ACK) ||
                    (state == S_STREAM);

  // Pop from the queue head (or bypass rd_data when empty), then push the arriving read
  always_comb begin
    q0_n  = q0;
    q1_n  = q1;
    cnt_n = cnt;
    if (pop && cnt != 2'd0) begin
      q0_n  = q1;
      cnt_n = cnt - 2'd1;
    end
    if (pend && !(pop && cnt == 2'd0)) begin
      if (cnt_n == 2'd0) q0_n = rd_data;
      else q1_n = rd_data;
      cnt_n = cnt_n + 2'd1;
    end
  end

  assign issue = fetch_en && (fetch_left != 16'd0) &&
                 (cnt_n <= 2'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= S_IDLE;
      rd_addr                <= '0;
      commited_rd_address    <= '0;
      tx_data                <= '0;
      tx_data_valid          <= '0;
      tx_start               <= 1'b0;
      sent_frames_counter    <= '0;
      dropped_frames_counter <= '0;
      fp                     <= '0;
      lane_last              <= '0;
      fetch_left             <= '0;
      send_left              <= '0;
      q0                     <= '0;
      q1                     <= '0;
      cnt                    <= '0;
      pend                   <= 1'b0;
    end else begin
      q0   <= q0_n;
      q1   <= q1_n;
      cnt  <= cnt_n;
      pend <= issue;
      if (issue) begin
        rd_addr    <= rd_addr + AW'(1);
        fetch_left <= fetch_left - 16'd1;
      end
      if (pop) send_left <= send_left - 16'd1;
      unique case (state)
        S_IDLE: begin
          if (commited_wr_address != commited_rd_address) begin
            rd_addr <= commited_rd_address + AW'(1);
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          fp        <= AW'(hdr_words) + AW'(1);
          lane_last <= hdr_lanes;
          send_left <= hdr_words[15:0];
          if (hdr_ok) begin
            fetch_left <= hdr_words[15:0] - 16'd1;
            rd_addr    <= rd_addr + AW'(1);
            pend       <= 1'b1;
            state      <= S_LOAD;
          end else begin
            state <= S_DROP;
          end
        end
        S_LOAD: begin
          tx_data       <= head;
          tx_data_valid <= lanes_now;
          tx_start      <= 1'b1;
          state         <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_ack) begin
            tx_start <= 1'b0;
            if (send_left == 16'd0) begin
              tx_data_valid <= 8'h00;
              state         <= S_COMMIT;
            end else begin
              tx_data       <= head;
              tx_data_valid <= lanes_now;
              state <= (send_left == 16'd1) ? S_COMMIT : S_STREAM;
            end
          end
        end
        S_STREAM: begin
          tx_data       <= head;
          tx_data_valid <= lanes_now;
          if (send_left == 16'd1) state <= S_COMMIT;
        end
        S_DROP: begin
          commited_rd_address    <= commited_rd_address + fp;
          rd_addr                <= commited_rd_address + fp;
          dropped_frames_counter <= dropped_frames_counter + 32'd1;
          cnt                    <= '0;
          pend                   <= 1'b0;
          state                  <= S_IDLE;
        end
        S_COMMIT: begin
          tx_data_valid       <= 8'h00;
          commited_rd_address <= commited_rd_address + fp;
          rd_addr             <= commited_rd_address + fp;
          sent_frames_counter <= sent_frames_counter + 32'd1;
          cnt                 <= '0;
          pend                <= 1'b0;
          state               <= S_IDLE;
        end
      endcase
    end
  end

endmodule
